uart_tx: RTL and testbench

UART transmitter that serialises one byte into a standard 8N1 frame: one start bit (low), eight data bits LSB first, one stop bit (high). It is the transmit half of the UART alongside `uart_rx` and shares the same baud-tick generator output (`b_tick`, 16× oversampled). A frame is launched by a single-cycle start request. The block reports busy and done status to the controlling logic (command/echo path).

---
 rtl/uart_tx.sv | 136 +++++++++++++
 tb/tb_uart_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit.
// Bit timing is driven by the shared oversampling baud tick; all outputs are registered.
module uart_tx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_tick,
    input  logic       start_trigger,
    input  logic [7:0] tx_din,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bit_end;

    assign bit_end = b_tick && (tick_q == TICK_LAST);

    // Next-state and next-output logic; outputs are computed for the following cycle
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                tick_d = {CW{1'b0}};
                bit_d  = 3'd0;
                if (start_trigger) begin
                    shift_d = tx_din;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    shift_d = shift_q;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tick_d  = {CW{1'b0}};
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else if (b_tick) begin
                    tick_d = tick_q + CW'(1);
                end else begin
                    tick_d = tick_q;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    tick_d = {CW{1'b0}};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else if (b_tick) begin
                    tick_d = tick_q + CW'(1);
                end else begin
                    tick_d = tick_q;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    tick_d  = {CW{1'b0}};
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (b_tick) begin
                    tick_d = tick_q + CW'(1);
                end else begin
                    tick_d = tick_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset to an idle-high line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= {CW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_busy = busy_q;
    assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: b_tick every 4 clk, OVERSAMPLE 16, so one bit is 64 clk.
// Frames are decoded from the line by the bench and compared with hand-known bytes.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_tick = 1'b0;
    logic       start_trigger = 1'b0;
    logic [7:0] tx_din = 8'h00;
    logic       o_tx;
    logic       o_tx_busy;
    logic       o_tx_done;

    logic       tick_en = 1'b1;
    logic [1:0] tick_div = 2'd0;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx #(.OVERSAMPLE(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .b_tick       (b_tick),
        .start_trigger(start_trigger),
        .tx_din       (tx_din),
        .o_tx         (o_tx),
        .o_tx_busy    (o_tx_busy),
        .o_tx_done    (o_tx_done)
    );

    always #5 clk = ~clk;

    // One-clk baud tick every fourth cycle, frozen while tick_en is low
    always @(negedge clk) begin
        if (tick_en) begin
            tick_div = tick_div + 2'd1;
            b_tick   = (tick_div == 2'd3);
        end else begin
            b_tick = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Trigger aligned to a tick cycle so the start bit lasts a full 64 clk
    task automatic launch(input logic [7:0] b);
        bit found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (b_tick) found = 1'b1;
        end
        check_eq("launch_tick", {31'd0, found}, 32'd1);
        start_trigger = 1'b1;
        tx_din        = b;
        step();
        start_trigger = 1'b0;
        tx_din        = ~b;
    endtask

    // Called at sample 0 of a frame; returns positioned on the done cycle
    task automatic frame_check(input string tag, input logic [7:0] exp, input int start_len,
                               input int poke_at, input int stall_at);
        int total;
        int good[10];
        int busy_cnt;
        int done_cnt;
        int j;
        logic e;
        logic [7:0] got_b;
        total    = start_len + 9 * 64;
        busy_cnt = 0;
        done_cnt = 0;
        got_b    = 8'h00;
        for (int i = 0; i < 10; i++) good[i] = 0;
        for (int k = 0; k < total; k++) begin
            j = (k < start_len) ? 0 : 1 + (k - start_len) / 64;
            e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp[j-1];
            if (o_tx === e) good[j]++;
            if (j >= 1 && j <= 8 && ((k - start_len) % 64) == 32) got_b[j-1] = o_tx;
            if (o_tx_busy === 1'b1) busy_cnt++;
            if (o_tx_done === 1'b1) done_cnt++;
            if (k == poke_at) begin
                start_trigger = 1'b1;
                tx_din        = 8'h7E;
            end
            if (k == poke_at + 1) start_trigger = 1'b0;
            if (k == stall_at) tick_en = 1'b0;
            if (k == stall_at + 1000) tick_en = 1'b1;
            step();
        end
        for (int i = 0; i < 10; i++)
            check_eq($sformatf("%s_bit%0d_len", tag, i), good[i], (i == 0) ? start_len : 64);
        check_eq({tag, "_byte"}, {24'd0, got_b}, {24'd0, exp});
        check_eq({tag, "_busy_cnt"}, busy_cnt, total);
        check_eq({tag, "_early_done"}, done_cnt, 0);
        check_eq({tag, "_done"}, {31'd0, o_tx_done}, 32'd1);
        check_eq({tag, "_done_busy"}, {31'd0, o_tx_busy}, 32'd0);
        check_eq({tag, "_done_tx"}, {31'd0, o_tx}, 32'd1);
    endtask

    task automatic idle_check(input string tag, input int n);
        int ok;
        ok = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (o_tx === 1'b1 && o_tx_done === 1'b0 && o_tx_busy === 1'b0) ok++;
        end
        check_eq(tag, ok, n);
    endtask

    initial begin
        logic [7:0] loop_bytes [3];
        loop_bytes[0] = 8'h00;
        loop_bytes[1] = 8'hFF;
        loop_bytes[2] = 8'hA5;

        repeat (3) step();
        check_eq("rst_tx", {31'd0, o_tx}, 32'd1);
        check_eq("rst_busy", {31'd0, o_tx_busy}, 32'd0);
        check_eq("rst_done", {31'd0, o_tx_done}, 32'd0);
        rst = 1'b0;
        idle_check("idle_after_rst", 8);

        launch(8'h55);
        frame_check("f55", 8'h55, 64, -1, -1);
        idle_check("f55_post", 10);

        for (int i = 0; i < 3; i++) begin
            launch(loop_bytes[i]);
            frame_check($sformatf("loop%0d", i), loop_bytes[i], 64, -1, -1);
            idle_check($sformatf("loop%0d_idle", i), 12);
        end

        launch(8'h3C);
        frame_check("b2b_first", 8'h3C, 64, -1, -1);
        start_trigger = 1'b1;
        tx_din        = 8'hC3;
        step();
        start_trigger = 1'b0;
        tx_din        = 8'h00;
        check_eq("b2b_no_gap_tx", {31'd0, o_tx}, 32'd0);
        check_eq("b2b_no_gap_busy", {31'd0, o_tx_busy}, 32'd1);
        frame_check("b2b_second", 8'hC3, 63, -1, -1);
        idle_check("b2b_idle", 10);

        launch(8'h81);
        frame_check("busy_ign", 8'h81, 64, 300, -1);
        idle_check("busy_no_second", 700);

        launch(8'h5A);
        repeat (280) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_tx", {31'd0, o_tx}, 32'd1);
        check_eq("midrst_busy", {31'd0, o_tx_busy}, 32'd0);
        check_eq("midrst_done", {31'd0, o_tx_done}, 32'd0);
        idle_check("midrst_idle", 20);
        launch(8'h12);
        frame_check("after_rst", 8'h12, 64, -1, -1);
        idle_check("after_rst_idle", 10);

        launch(8'hE7);
        frame_check("stall", 8'hE7, 64 + 1000, -1, 20);
        idle_check("stall_idle", 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
